cheat_engine_n: RTL
===================

Name: cheat_engine_n

Overview:
- Parametrised successor of the fixed six-slot ROM cheat matcher.
- Holds NUM_SLOTS address/data patch slots, each with a per-slot mode: off, persistent, or hit-limited.
- Keeps a saturating hit counter per slot, a global enable, and a post-reset/triggered hold-off timer.
- Sits beside the SNES bus decoder; drives substitute data and cheat_hit into the cartridge data mux.

Parameters:
- NUM_SLOTS, 8, number of patch slots (1..2^IDX_W).
- IDX_W, 3, width of slot index fields.
- ADDR_W, 24, SNES address width.
- DATA_W, 8, patch data width.
- HIT_W, 8, per-slot hit counter and limit width.
- HOLDOFF_W, 24, hold-off counter width.
- HOLDOFF_CYCLES, 24'd9600000, hold-off load value (nonzero, must fit HOLDOFF_W).

Ports:
- clk  in  1  system clock; all state is on posedge.
- SNES_reset_strobe  in  1  synchronous active-high reset.
- SNES_ADDR  in  ADDR_W  current bus address.
- SNES_rd_strobe  in  1  one-cycle pulse per completed SNES read.
- holdoff_trigger  in  1  one-cycle pulse that restarts hold-off.
- pgm_we  in  1  program strobe.
- pgm_idx  in  IDX_W  target slot.
- pgm_sel  in  2  0: addr/data, 1: mode/limit, 2: clear hit counter, 3: global control.
- pgm_in  in  32  program payload.
- rd_idx  in  IDX_W  hit-counter readback select.
- data_out  out  DATA_W  substitute data.
- cheat_hit  out  1  substitute data valid.
- hit_idx  out  IDX_W  winning slot.
- holdoff_active  out  1  hold-off counter nonzero.
- rd_hits  out  HIT_W  registered hit count of slot rd_idx.

Behaviour:
- Reset (SNES_reset_strobe=1) clears:
  - every slot: addr=0, data=0, mode=off, limit=0, hits=0;
  - cheat_enable=0 and rd_hits=0.
- Reset loads holdoff=HOLDOFF_CYCLES, so holdoff_active=1 from the cycle after reset.
- Reset has priority over every other input in the same cycle.
- Slot programming (pgm_we=1):
  - pgm_idx>=NUM_SLOTS: ignored, no state change.
  - sel 0: addr=pgm_in[ADDR_W+7:8], data=pgm_in[DATA_W-1:0], and the slot's hits are cleared.
  - sel 1: mode=pgm_in[1:0] (00 off, 01 persistent, 10 limited, 11 treated as off) and limit=pgm_in[HIT_W+7:8]; hits are unchanged.
  - sel 2: hits=0.
- Global control (pgm_sel 3, pgm_idx ignored):
  - cheat_enable <= (cheat_enable & ~pgm_in[8]) | pgm_in[0];
  - pgm_in[1]=1 restarts hold-off.
- A slot is active when either holds:
  - mode=01;
  - mode=10 and hits<limit. limit=0 means never active.
- Match (combinational, same cycle as SNES_ADDR):
  - match[i] = active[i] & (SNES_ADDR==addr[i]).
  - Winner is the lowest matching index.
  - cheat_hit = cheat_enable & ~holdoff_active & |match.
  - hit_idx = winner index, or 0 when there is no match.
  - data_out = data[winner], or 0 when there is no match.
- Counting: on SNES_rd_strobe with cheat_hit=1, hits[winner] increments by 1 and saturates at 2^HIT_W-1.
  - Only the winner counts; lower-priority matches are not counted.
  - A limited slot goes inactive in the cycle after its hits reaches limit.
  - The counter never exceeds limit.
- Same-cycle collisions between programming and counting:
  - pgm_we sel 0 or sel 2 to the winning slot: the clear wins and the increment is dropped.
  - sel 1 on the winning slot: the increment still applies.
- Hold-off:
  - Counter decrements by 1 per cycle while nonzero.
  - holdoff_trigger or a sel-3 pgm_in[1] reloads HOLDOFF_CYCLES, including mid-countdown.
  - holdoff_active = (holdoff!=0).
- Readback: rd_hits <= hits[rd_idx] each cycle (1-cycle latency); rd_idx>=NUM_SLOTS returns 0.
- A programming write reaches data_out/cheat_hit on the next cycle.

Test Plan:
- Reset, wait HOLDOFF_CYCLES-1 cycles -> holdoff_active=1. One cycle later holdoff_active=0; cheat_hit stays 0 throughout.
- After hold-off expiry, program:
  - slot 2 with addr 24'h008123, data 8'hEA, mode 01;
  - cheat_enable set.
  Drive 24'h008123 -> cheat_hit=1, data_out=8'hEA, hit_idx=2. Drive 24'h008124 -> cheat_hit=0, data_out=0.
- Program slots 1 and 5 with the same address (data 8'h11 and 8'h55), then issue 3 reads -> data_out=8'h11, hit_idx=1. rd_hits reads 3 for slot 1 and 0 for slot 5.
- Program slot 0 as limited, limit=2, then issue 3 read strobes on its address -> hits on reads 1 and 2, no hit on read 3. rd_hits=2.
- Same cycle: SNES_rd_strobe with slot 0 winning, plus pgm_we sel 2 to slot 0 -> hits=0 next cycle. Then pulse holdoff_trigger mid-operation -> cheat_hit=0 for HOLDOFF_CYCLES cycles.
- Set HIT_W=2 with a persistent slot and issue 5 hits -> count saturates at 3. pgm_idx=NUM_SLOTS with NUM_SLOTS=6 leaves all state unchanged.

Source files
------------

// File: rtl/cheat_engine_n.sv
// ---------------------------------------------------------------------------
// cheat_engine_n
//   Parametrised ROM patch matcher that sits beside the SNES bus decoder.
//   NUM_SLOTS address/data slots, each either off, persistent or limited to a
//   programmable number of hits. A per-slot saturating hit counter, a global
//   enable and a hold-off timer (restarted by reset or by a trigger) control
//   whether substitute data is offered to the cartridge data mux.
//
// Ports
//   clk               system clock, all state on posedge
//   SNES_reset_strobe synchronous active-high reset
//   SNES_ADDR         current bus address
//   SNES_rd_strobe    one-cycle pulse per completed read
//   holdoff_trigger   one-cycle pulse that restarts the hold-off timer
//   pgm_we/idx/sel/in programming interface
//                     sel 0 addr/data, 1 mode/limit, 2 clear hits, 3 global
//   rd_idx            hit-counter readback select
//   data_out          substitute data (0 when nothing matches)
//   cheat_hit         substitute data valid
//   hit_idx           winning slot (0 when nothing matches)
//   holdoff_active    hold-off timer nonzero
//   rd_hits           registered hit count of slot rd_idx
// ---------------------------------------------------------------------------
module cheat_engine_n #(
   parameter int                   NUM_SLOTS      = 8,
   parameter int                   IDX_W          = 3,
   parameter int                   ADDR_W         = 24,
   parameter int                   DATA_W         = 8,
   parameter int                   HIT_W          = 8,
   parameter int                   HOLDOFF_W      = 24,
   parameter logic [HOLDOFF_W-1:0] HOLDOFF_CYCLES = 24'd9600000
) (
   input  logic              clk,
   input  logic              SNES_reset_strobe,
   input  logic [ADDR_W-1:0] SNES_ADDR,
   input  logic              SNES_rd_strobe,
   input  logic              holdoff_trigger,
   input  logic              pgm_we,
   input  logic [IDX_W-1:0]  pgm_idx,
   input  logic [1:0]        pgm_sel,
   input  logic [31:0]       pgm_in,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] data_out,
   output logic              cheat_hit,
   output logic [IDX_W-1:0]  hit_idx,
   output logic              holdoff_active,
   output logic [HIT_W-1:0]  rd_hits
);

   localparam logic [HIT_W-1:0] HIT_MAX = '1;

   localparam logic [1:0] MODE_PERSIST = 2'b01;
   localparam logic [1:0] MODE_LIMITED = 2'b10;

   logic [NUM_SLOTS-1:0] match;
   logic [DATA_W-1:0]    slot_data [NUM_SLOTS];
   logic [HIT_W-1:0]     slot_hits [NUM_SLOTS];

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [DATA_W-1:0]    win_data;

   logic                 enable_q, enable_d;
   logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
   logic [HIT_W-1:0]     rd_hits_q, rd_hits_d;

   // -----------------------------------------------------------------------
   // Per-slot state and match logic
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         logic [ADDR_W-1:0] addr_q, addr_d;
         logic [DATA_W-1:0] data_q, data_d;
         logic [1:0]        mode_q, mode_d;
         logic [HIT_W-1:0]  limit_q, limit_d;
         logic [HIT_W-1:0]  hits_q, hits_d;
         logic              slot_we;
         logic              active;

         // Out-of-range pgm_idx never equals any slot number, so it is
         // dropped without a separate range check.
         assign slot_we = pgm_we && (pgm_idx == IDX_W'(gi));

         // limit=0 never satisfies hits<limit, so such a slot stays off.
         assign active = (mode_q == MODE_PERSIST) ||
                         ((mode_q == MODE_LIMITED) && (hits_q < limit_q));

         assign match[gi]     = active && (SNES_ADDR == addr_q);
         assign slot_data[gi] = data_q;
         assign slot_hits[gi] = hits_q;

         always_comb begin
            addr_d  = addr_q;
            data_d  = data_q;
            mode_d  = mode_q;
            limit_d = limit_q;
            hits_d  = hits_q;

            if (SNES_rd_strobe && cheat_hit && (win_idx == IDX_W'(gi)) &&
                (hits_q != HIT_MAX)) begin
               hits_d = hits_q + HIT_W'(1);
            end

            // Clears are applied after the increment so they win a collision;
            // a mode/limit write leaves the increment in place.
            if (slot_we) begin
               case (pgm_sel)
                  2'd0: begin
                     addr_d = pgm_in[ADDR_W+7:8];
                     data_d = pgm_in[DATA_W-1:0];
                     hits_d = '0;
                  end
                  2'd1: begin
                     mode_d  = pgm_in[1:0];
                     limit_d = pgm_in[HIT_W+7:8];
                  end
                  2'd2: hits_d = '0;
                  default: ;
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (SNES_reset_strobe) begin
               addr_q  <= '0;
               data_q  <= '0;
               mode_q  <= '0;
               limit_q <= '0;
               hits_q  <= '0;
            end else begin
               addr_q  <= addr_d;
               data_q  <= data_d;
               mode_q  <= mode_d;
               limit_q <= limit_d;
               hits_q  <= hits_d;
            end
         end
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Priority select: lowest matching slot wins
   // -----------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!win_found && match[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
            win_data  = slot_data[i];
         end
      end
   end

   // -----------------------------------------------------------------------
   // Global enable, hold-off timer and hit readback
   // -----------------------------------------------------------------------
   always_comb begin
      enable_d  = enable_q;
      holdoff_d = holdoff_q;
      if (holdoff_q != '0) begin
         holdoff_d = holdoff_q - HOLDOFF_W'(1);
      end
      if (pgm_we && (pgm_sel == 2'd3)) begin
         // Set bit dominates clear bit when both are written together.
         enable_d = (enable_q & ~pgm_in[8]) | pgm_in[0];
         if (pgm_in[1]) begin
            holdoff_d = HOLDOFF_CYCLES;
         end
      end
      if (holdoff_trigger) begin
         holdoff_d = HOLDOFF_CYCLES;
      end
   end

   always_comb begin
      rd_hits_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_hits_d = slot_hits[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (SNES_reset_strobe) begin
         enable_q  <= 1'b0;
         holdoff_q <= HOLDOFF_CYCLES;
         rd_hits_q <= '0;
      end else begin
         enable_q  <= enable_d;
         holdoff_q <= holdoff_d;
         rd_hits_q <= rd_hits_d;
      end
   end

   assign holdoff_active = (holdoff_q != '0);
   assign cheat_hit      = enable_q && !holdoff_active && win_found;
   assign hit_idx        = win_idx;
   assign data_out       = win_data;
   assign rd_hits        = rd_hits_q;

endmodule
